// File: rtl/mem_result_pkg.sv
// Shared definitions for the result-word memory writer: FSM encoding,
// well-known pass/fail port values and the packed FIFO entry layout.
package mem_result_pkg;

  // Writer FSM encoding; values are visible on the debug state output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_GAP   = 2'b10
  } wr_state_e;

  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 32;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  // Address of the test port watched by the pass/fail monitor and the
  // word that signals a passing run.
  localparam logic [ADDR_W-1:0] TEST_PORT_ADDR = 30'd0;
  localparam logic [DATA_W-1:0] PASS_WORD      = 32'd60;

  // Entry layout in the FIFO: address in the upper bits, data below.
  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {addr, data};
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO holding queued (address, data) result words.
// Pointers carry one extra wrap bit so full and empty are told apart by
// comparing the MSBs; the index bits wrap for free because DEPTH is 2^n.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 62
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is dropped; a pop from an empty one is a no-op.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards every pending entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mem_result_writer.sv
// Bus-side transmitter for result words headed to the data-memory write port.
// Words are queued in a small FIFO and each is issued as one write with
// mem_wen held high until the memory stops stalling, followed by a forced
// wen-low gap so edge-counting observers see every write exactly once.
//
// Handshakes:
//   input side  - a word transfers on a rising edge where in_valid && in_ready;
//                 in_ready depends only on the registered full flag, so a pop
//                 on the same edge does not open a slot until the next cycle.
//   memory side - a write is accepted on a rising edge where mem_wen && !mem_stall;
//                 mem_addr/mem_wdata stay stable for as long as mem_wen is high.
module mem_result_writer
  import mem_result_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [29:0]       in_addr,
  input  logic [31:0]       in_data,
  input  logic              mem_stall,
  output logic [29:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_wen,
  output logic              busy,
  output logic [CNT_W-1:0]  sent_count,
  output wr_state_e         dbg_state
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  wr_state_e          state;
  logic [GAP_W-1:0]   gap_cnt;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;

  // The head is consumed exactly when IDLE launches a new write.
  assign fifo_push = in_valid && !fifo_full;
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;

  assign in_ready  = !fifo_full;
  assign busy      = !fifo_empty || (state != ST_IDLE);
  assign dbg_state = state;

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (pack_entry(in_addr, in_data)),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Write sequencer: launch from the FIFO head, hold through stalls, then
  // keep wen low for the gap before the next launch is allowed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      sent_count <= '0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            mem_addr  <= fifo_rdata[ENTRY_W-1:DATA_W];
            mem_wdata <= fifo_rdata[DATA_W-1:0];
            mem_wen   <= 1'b1;
            state     <= ST_WRITE;
          end else begin
            mem_wen <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (!mem_stall) begin
            if (sent_count != {CNT_W{1'b1}}) sent_count <= sent_count + CNT_W'(1);
            mem_wen <= 1'b0;
            gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          mem_wen <= 1'b0;
          if (gap_cnt == '0) state <= ST_IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: begin
          mem_wen <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_result_writer.sv
// Bench for mem_result_writer: directed scenarios with literal expectations,
// then randomized traffic and stalls checked every cycle against a
// transaction-level model (pending-word queue, in-flight write, wen-low hold).
module tb_mem_result_writer;
  import mem_result_pkg::*;

  localparam int DEPTH      = 4;
  localparam int GAP_CYCLES = 1;
  localparam int CNT_W      = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid;
  logic [29:0] in_addr;
  logic [31:0] in_data;
  logic        mem_stall;

  logic             in_ready, mem_wen, busy;
  logic [29:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [CNT_W-1:0] sent_count;
  wr_state_e        dbg_state;

  logic        in_ready2, mem_wen2, busy2;
  logic [29:0] mem_addr2;
  logic [31:0] mem_wdata2;
  logic [1:0]  sent_count2;
  wr_state_e   dbg_state2;

  mem_result_writer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .mem_stall(mem_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .busy(busy), .sent_count(sent_count), .dbg_state(dbg_state)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  mem_result_writer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_addr(in_addr), .in_data(in_data), .mem_stall(mem_stall),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_wen(mem_wen2),
    .busy(busy2), .sent_count(sent_count2), .dbg_state(dbg_state2)
  );

  // ---------------- checking utilities ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // exp_q holds words accepted but not yet launched. A launched word stays on
  // the bus until a stall-free edge; after that, GAP_CYCLES edges must pass
  // with wen low, then one more idle edge is needed to launch the next word.
  logic [61:0] exp_q[$];
  logic        m_active;
  logic [29:0] m_addr;
  logic [31:0] m_data;
  int          m_hold;
  int          m_sent;
  bit          m_ready_pre;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_active = 1'b0;
      m_addr   = '0;
      m_data   = '0;
      m_hold   = 0;
      m_sent   = 0;
    end else begin
      m_ready_pre = (exp_q.size() < DEPTH);
      if (m_active) begin
        if (!mem_stall) begin
          m_active = 1'b0;
          m_sent++;
          m_hold = GAP_CYCLES;
        end
      end else if (m_hold > 0) begin
        m_hold--;
      end else if (exp_q.size() > 0) begin
        {m_addr, m_data} = exp_q.pop_front();
        m_active = 1'b1;
      end
      if (in_valid && m_ready_pre) exp_q.push_back({in_addr, in_data});
    end
  end

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("wen",      {63'd0, mem_wen},   {63'd0, m_active});
      chk("addr",     64'(mem_addr),      64'(m_addr));
      chk("wdata",    64'(mem_wdata),     64'(m_data));
      chk("in_ready", {63'd0, in_ready},  64'(exp_q.size() < DEPTH));
      chk("busy",     {63'd0, busy},      64'(exp_q.size() > 0 || m_active || m_hold > 0));
      chk("sent",     64'(sent_count),    64'(sat(m_sent, 255)));
      chk("wen_n2",   {63'd0, mem_wen2},  {63'd0, m_active});
      chk("addr_n2",  64'({mem_addr2, mem_wdata2}), 64'({m_addr, m_data}));
      chk("sent_n2",  64'(sent_count2),   64'(sat(m_sent, 3)));
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after the push edge.
  task automatic push_one(input logic [29:0] a, input logic [31:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", {63'd0, busy}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  logic ready_after [5];

  initial begin
    in_valid = 1'b0; in_addr = '0; in_data = '0; mem_stall = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_wen",   {63'd0, mem_wen},  64'd0);
    chk("rst_addr",  64'(mem_addr),     64'd0);
    chk("rst_data",  64'(mem_wdata),    64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_busy",  {63'd0, busy},     64'd0);
    chk("rst_sent",  64'(sent_count),   64'd0);
    chk("rst_state", 64'(dbg_state),    64'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Pass word to the test port: wen high exactly one cycle, two cycles out
    push_one(TEST_PORT_ADDR, PASS_WORD);
    chk("t1_wen_early", {63'd0, mem_wen}, 64'd0);
    chk("t1_busy",      {63'd0, busy},    64'd1);
    @(negedge clk);
    chk("t1_wen",  {63'd0, mem_wen}, 64'd1);
    chk("t1_addr", 64'(mem_addr),    64'd0);
    chk("t1_data", 64'(mem_wdata),   64'd60);
    @(negedge clk);
    chk("t1_wen_low", {63'd0, mem_wen}, 64'd0);
    chk("t1_sent",    64'(sent_count),  64'd1);
    wait_idle();

    // Stall for three edges: wen high four cycles with a stable payload
    mem_stall = 1'b1;
    push_one(30'd5, 32'hDEAD);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t2_wen",  {63'd0, mem_wen}, 64'd1);
      chk("t2_addr", 64'(mem_addr),    64'd5);
      chk("t2_data", 64'(mem_wdata),   64'hDEAD);
      if (k == 4) mem_stall = 1'b0;
    end
    @(negedge clk);
    chk("t2_wen_low", {63'd0, mem_wen}, 64'd0);
    chk("t2_sent",    64'(sent_count),  64'd2);
    wait_idle();

    // Fill the FIFO behind a stalled write; the fifth back-to-back push is dropped
    mem_stall = 1'b1;
    push_one(30'd1, 32'd100);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_addr  = 30'(10 + i);
      in_data  = 32'(200 + i);
      @(negedge clk);
      ready_after[i] = in_ready;
    end
    in_valid = 1'b0;
    chk("t3_ready_after3", {63'd0, ready_after[2]}, 64'd1);
    chk("t3_ready_after4", {63'd0, ready_after[3]}, 64'd0);
    chk("t3_ready_after5", {63'd0, ready_after[4]}, 64'd0);
    mem_stall = 1'b0;
    wait_idle();
    chk("t3_sent", 64'(sent_count), 64'd7);

    // Push on the very edge that IDLE pops the last entry
    push_one(30'd7, 32'hAAAA_0001);
    push_one(30'd8, 32'hAAAA_0002);
    wait_idle();
    chk("t6_sent", 64'(sent_count), 64'd9);

    // Reset mid-write with two entries queued
    mem_stall = 1'b1;
    push_one(30'd20, 32'd1);
    push_one(30'd21, 32'd2);
    push_one(30'd22, 32'd3);
    chk("t4_wen_before", {63'd0, mem_wen}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t4_wen",   {63'd0, mem_wen},  64'd0);
    chk("t4_ready", {63'd0, in_ready}, 64'd1);
    chk("t4_busy",  {63'd0, busy},     64'd0);
    chk("t4_sent",  64'(sent_count),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_stall = 1'b0;
    repeat (10) @(negedge clk);
    chk("t4_no_write", {63'd0, mem_wen}, 64'd0);
    chk("t4_sent_after", 64'(sent_count), 64'd0);

    // Randomized traffic and stalls
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 50);
      in_addr   = 30'($urandom);
      in_data   = $urandom;
      mem_stall = ($urandom_range(0, 99) < 30);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    mem_stall = 1'b0;
    wait_idle();
    chk("t5_sat2", 64'(sent_count2), 64'd3);
    chk("sat8",    64'(sent_count),  64'd255);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

endmodule
